// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_wb #(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    localparam logic [1:0] COMPARE   = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             req, hit, miss, write_hit, fill;

    assign off = proc_addr[1:0];
    assign idx = proc_addr[2 +: IDX_W];
    assign tag = proc_addr[29 -: TAG_W];

    // A store wins over a load when both request lines are high.
    assign req       = proc_read | proc_write;
    assign hit       = (state_q == COMPARE) && req && valid_q[idx] && (tag_q[idx] == tag);
    assign miss      = (state_q == COMPARE) && req && !hit;
    assign write_hit = hit && proc_write;
    assign fill      = (state_q == ALLOCATE) && mem_ready;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            COMPARE: begin
                if (hit) begin
                    if (!proc_write) proc_rdata = data_q[idx][{off, 5'b0} +: 32];
                end else if (req) begin
                    proc_stall = 1'b1;
                    state_d    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = data_q[idx];
                if (mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) state_d = COMPARE;
            end
            default: state_d = COMPARE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COMPARE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (write_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag/data storage has no reset; valid_q alone decides whether a line's contents mean anything.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
        end else if (write_hit) begin
            data_q[idx][{off, 5'b0} +: 32] <= proc_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: directed scenarios plus random traffic
// against a line/memory reference model; counter checks need DCACHE_STATS_EN.
module tb_dcache_wb;

    localparam int NL    = 8;
    localparam int IDX_W = $clog2(NL);

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [15:0]  hit_cnt, miss_cnt;
`endif

    dcache_wb #(.NUM_LINES(NL)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: cache lines and backing memory, indexed by plain arithmetic.
    bit           m_valid [NL];
    bit           m_dirty [NL];
    int unsigned  m_tag   [NL];
    logic [127:0] m_data  [NL];
    logic [127:0] mem_model [int unsigned];

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_get(input int unsigned blk);
        if (!mem_model.exists(blk)) mem_model[blk] = {$urandom, $urandom, $urandom, $urandom};
        return mem_model[blk];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_stall"}, proc_stall, 0);
        check({name, "_rdata"}, proc_rdata, 0);
        check({name, "_mrd"},   mem_read,   0);
        check({name, "_mwr"},   mem_write,  0);
        check({name, "_maddr"}, mem_addr,   0);
        check({name, "_mwdat"}, mem_wdata,  0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        rst        = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // One memory transfer: mem_ready arrives after dly waiting cycles.
    task automatic mem_phase(input bit is_wb, input int unsigned exp_addr,
                             input logic [127:0] blk, input int dly);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            mem_ready = (c == dly);
            mem_rdata = is_wb ? {$urandom, $urandom, $urandom, $urandom} : blk;
            #1;
            check(is_wb ? "wb_mwr" : "al_mwr", mem_write, is_wb);
            check(is_wb ? "wb_mrd" : "al_mrd", mem_read, !is_wb);
            check(is_wb ? "wb_addr" : "al_addr", mem_addr, 28'(exp_addr));
            check(is_wb ? "wb_stall" : "al_stall", proc_stall, 1);
            if (is_wb) check("wb_data", mem_wdata, blk);
        end
        @(posedge clk);
        #1 mem_ready = 1'b0;
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [29:0] addr,
                             input logic [31:0] wd, input int dly);
        int unsigned idx, tg, blk, w;
        idx = (addr >> 2) % NL;
        tg  = addr >> (2 + IDX_W);
        blk = addr >> 2;
        w   = addr % 4;
        @(negedge clk);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        #1;
        if (!(rd || wr)) begin
            check("idle_stall", proc_stall, 0);
            check("idle_rdata", proc_rdata, 0);
            check("idle_mrd", mem_read, 0);
            check("idle_mwr", mem_write, 0);
            @(posedge clk);
            return;
        end
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            check("miss_stall", proc_stall, 1);
            check("miss_mrd", mem_read, 0);
            check("miss_mwr", mem_write, 0);
            @(posedge clk);
            if (m_valid[idx] && m_dirty[idx]) begin
                mem_phase(1'b1, m_tag[idx] * NL + idx, m_data[idx], dly);
                mem_model[m_tag[idx] * NL + idx] = m_data[idx];
            end
            mem_phase(1'b0, blk, mem_get(blk), dly);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = mem_get(blk);
            @(negedge clk);
            #1;
        end
        check("hit_stall", proc_stall, 0);
        check("hit_mrd", mem_read, 0);
        check("hit_mwr", mem_write, 0);
        if (!wr) check("hit_rdata", proc_rdata, m_data[idx][w*32 +: 32]);
        if (wr) begin
            m_data[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        clear_model();
        mem_model[4] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hAAAA_0000};
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Cold read miss on 0x10, then fill and retry hit.
        do_access(1'b1, 1'b0, 30'h10, 32'h0, 2);
        check("cold_rdata_model", m_data[4][31:0], 32'hAAAA_0000);

        // Store then load on the resident line.
        do_access(1'b0, 1'b1, 30'h10, 32'hDEAD_BEEF, 0);
        do_access(1'b1, 1'b0, 30'h10, 32'h0, 0);

        // Dirty line at index 0 evicted by a conflicting tag.
        do_access(1'b0, 1'b1, 30'h0, 32'h1234_5678, 1);
        do_access(1'b1, 1'b0, 30'h20, 32'h0, 3);
        do_access(1'b1, 1'b0, 30'h0, 32'h0, 1);

        // Slow memory: 20 cycles of waiting per transfer.
        do_access(1'b1, 1'b1, 30'h20, 32'hCAFE_F00D, 0);
        do_access(1'b1, 1'b0, 30'h40, 32'h0, 20);

        // Reset in the middle of an ALLOCATE.
        apply_reset();
        do_access(1'b1, 1'b0, 30'h10, 32'h0, 0);
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h44;
        @(posedge clk);
        #1;
        check("pre_rst_mrd", mem_read, 1);
        #2;
        proc_read = 1'b0;
        rst       = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = {4{32'h5555_5555}};
        #1;
        check("late_ready_mrd", mem_read, 0);
        check("late_ready_stall", proc_stall, 0);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("after_ready_mrd", mem_read, 0);
        check("after_ready_mwr", mem_write, 0);
        do_access(1'b1, 1'b0, 30'h10, 32'h0, 1);

        // Random traffic over four tags so hits, clean misses and evictions all occur.
        for (int n = 0; n < 200; n++) begin
            int unsigned op, a;
            op = $urandom_range(0, 4);
            a  = ($urandom_range(0, 3) << (2 + IDX_W)) | ($urandom_range(0, NL - 1) << 2)
                 | $urandom_range(0, 3);
            do_access(op == 1 || op == 2 || op == 4, op >= 3, 30'(a), $urandom,
                      $urandom_range(0, 4));
        end

`ifdef DCACHE_STATS_EN
        apply_reset();
        do_access(1'b1, 1'b0, 30'h10, 32'h0, 0);
        for (int k = 0; k < 3; k++) do_access(1'b1, 1'b0, 30'h11, 32'h0, 0);
        #1;
        check("hit_cnt", hit_cnt, 16'd4);
        check("miss_cnt", miss_cnt, 16'd1);
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        do_access(1'b1, 1'b0, 30'h10, 32'h0, 0);
        #1;
        check("hit_cnt_sat", hit_cnt, 16'hFFFF);
        check("miss_cnt_hold", miss_cnt, 16'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
